// File: rtl/int_sequencer.sv
// Interrupt sequencer: latches irq rising edges, masks and prioritises them, and runs the
// interrupt/intAck/intDone handshake with nesting; the register block sits on the 8-bit I/O bus.
module int_sequencer #(
  parameter logic [7:0] SEQ_ADDRESS = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic [7:0] address,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] dout,
  output logic       interrupt,
  output logic [1:0] irqNum,
  input  logic       intAck,
  input  logic       intDone,
  input  logic       irq_0,
  input  logic       irq_1,
  input  logic       irq_2,
  input  logic       irq_3
);

  localparam logic [7:0] OFS_CTRL    = 8'd0;
  localparam logic [7:0] OFS_MASK    = 8'd1;
  localparam logic [7:0] OFS_PENDING = 8'd2;
  localparam logic [7:0] OFS_INSVC   = 8'd3;
  localparam logic [7:0] OFS_STATUS  = 8'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    ACKED  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       enable_q, enable_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] pending_q, pending_d;
  logic [3:0] in_service_q, in_service_d;
  logic [3:0] irq_prev_q, irq_prev_d;
  logic [1:0] irq_num_q, irq_num_d;
  logic       interrupt_q, interrupt_d;
  logic [7:0] dout_q, dout_d;

  logic [3:0] irq_vec, irq_rise, w1c_bits, ack_bit, done_bit;
  logic [3:0] eligible, allowed, serviceable;
  logic [7:0] offset, rd_data;
  logic       wr_ctrl, wr_mask, wr_pend, ack_fire, withdraw, any_svc;
  logic [1:0] svc_idx;
  logic [3:0] unused_din;

  assign unused_din = din[7:4];

  function automatic logic [3:0] lowest_onehot(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  always_comb begin
    irq_vec  = {irq_3, irq_2, irq_1, irq_0};
    irq_rise = irq_vec & ~irq_prev_q;
    offset   = address - SEQ_ADDRESS;
    wr_ctrl  = w_en && (offset == OFS_CTRL);
    wr_mask  = w_en && (offset == OFS_MASK);
    wr_pend  = w_en && (offset == OFS_PENDING);
    w1c_bits = wr_pend ? din[3:0] : 4'b0000;
    eligible = pending_q & mask_q & {4{enable_q}};
    // Bits strictly below the highest-priority in-service bit; all ones when nothing is in service.
    allowed     = lowest_onehot(in_service_q) - 4'd1;
    serviceable = eligible & allowed;
    any_svc     = |serviceable;
    svc_idx     = lowest_idx(serviceable);
  end

  always_comb begin
    state_d     = state_q;
    irq_num_d   = irq_num_q;
    interrupt_d = interrupt_q;
    enable_d    = wr_ctrl ? din[0] : enable_q;
    mask_d      = wr_mask ? din[3:0] : mask_q;
    irq_prev_d  = irq_vec;
    ack_fire    = (state_q == ASSERT) && intAck;
    ack_bit     = ack_fire ? (4'b0001 << irq_num_q) : 4'b0000;
    done_bit    = intDone ? lowest_onehot(in_service_q) : 4'b0000;
    // A fresh edge wins over a same-cycle clear of the same bit.
    pending_d    = (pending_q & ~(w1c_bits | ack_bit)) | irq_rise;
    in_service_d = (in_service_q & ~done_bit) | ack_bit;
    withdraw     = !(pending_d[irq_num_q] && mask_d[irq_num_q] && enable_d);

    case (state_q)
      IDLE: begin
        if (any_svc) begin
          state_d     = ASSERT;
          irq_num_d   = svc_idx;
          interrupt_d = 1'b1;
        end
      end
      ASSERT: begin
        if (ack_fire) begin
          state_d     = ACKED;
          interrupt_d = 1'b0;
        end else if (withdraw) begin
          state_d     = IDLE;
          interrupt_d = 1'b0;
        end
      end
      ACKED: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        interrupt_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    rd_data = 8'h00;
    case (offset)
      OFS_CTRL:    rd_data = {7'b0, enable_q};
      OFS_MASK:    rd_data = {4'b0, mask_q};
      OFS_PENDING: rd_data = {4'b0, pending_q};
      OFS_INSVC:   rd_data = {4'b0, in_service_q};
      OFS_STATUS:  rd_data = {3'b0, state_q, interrupt_q, irq_num_q};
      default:     rd_data = 8'h00;
    endcase
    dout_d = r_en ? rd_data : dout_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      enable_q     <= 1'b0;
      mask_q       <= 4'b0000;
      pending_q    <= 4'b0000;
      in_service_q <= 4'b0000;
      irq_prev_q   <= 4'b0000;
      irq_num_q    <= 2'd0;
      interrupt_q  <= 1'b0;
      dout_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      enable_q     <= enable_d;
      mask_q       <= mask_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      irq_prev_q   <= irq_prev_d;
      irq_num_q    <= irq_num_d;
      interrupt_q  <= interrupt_d;
      dout_q       <= dout_d;
    end
  end

  assign dout      = dout_q;
  assign interrupt = interrupt_q;
  assign irqNum    = irq_num_q;

endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: directed handshake/nesting scenarios plus a random run against a
// reference model that keeps in-service levels as a nesting stack.
module tb_int_sequencer;

  localparam logic [7:0] BASE = 8'h40;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] address = 8'h00;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic [7:0] dout;
  logic       interrupt;
  logic [1:0] irqNum;
  logic       intAck = 1'b0;
  logic       intDone = 1'b0;
  logic [3:0] irq = 4'b0000;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  int_sequencer #(.SEQ_ADDRESS(BASE)) dut (
    .clk(clk), .reset(reset), .din(din), .address(address), .w_en(w_en), .r_en(r_en),
    .dout(dout), .interrupt(interrupt), .irqNum(irqNum), .intAck(intAck), .intDone(intDone),
    .irq_0(irq[0]), .irq_1(irq[1]), .irq_2(irq[2]), .irq_3(irq[3])
  );

  // Reference model: pending/mask/enable bits, a nesting stack of serviced irqs, request phase.
  logic [3:0] m_pend, m_mask, m_prev;
  logic       m_en, m_req, m_gap;
  logic [1:0] m_num;
  logic [7:0] m_dout;
  int         m_stack[$];

  task automatic model_reset();
    m_pend = 0; m_mask = 0; m_prev = 0; m_en = 0; m_req = 0; m_gap = 0;
    m_num = 0; m_dout = 0; m_stack.delete();
  endtask

  function automatic logic [3:0] stack_bits();
    logic [3:0] b = 4'b0000;
    foreach (m_stack[k]) b[m_stack[k]] = 1'b1;
    return b;
  endfunction

  task automatic model_step();
    logic [3:0] rise, clr, pend_n, mask_n;
    logic       en_n;
    logic [7:0] off;
    int         top, sel;
    rise = irq & ~m_prev;
    off = address - BASE;
    clr = 4'b0000; mask_n = m_mask; en_n = m_en;
    if (r_en) begin
      case (off)
        8'd0: m_dout = {7'b0, m_en};
        8'd1: m_dout = {4'b0, m_mask};
        8'd2: m_dout = {4'b0, m_pend};
        8'd3: m_dout = {4'b0, stack_bits()};
        8'd4: m_dout = {5'b0, m_req, m_num};
        default: m_dout = 8'h00;
      endcase
    end
    if (w_en) begin
      if (off == 8'd0) en_n = din[0];
      else if (off == 8'd1) mask_n = din[3:0];
      else if (off == 8'd2) clr = din[3:0];
    end
    top = (m_stack.size() == 0) ? 4 : m_stack[m_stack.size() - 1];
    sel = -1;
    for (int i = 3; i >= 0; i--)
      if (m_pend[i] && m_mask[i] && m_en && i < top) sel = i;
    if (intDone && m_stack.size() > 0) void'(m_stack.pop_back());
    if (m_req && intAck) begin
      m_stack.push_back(int'(m_num));
      clr[m_num] = 1'b1;
      m_req = 1'b0;
      m_gap = 1'b1;
    end
    pend_n = (m_pend & ~clr) | rise;
    if (m_req) begin
      if (!(pend_n[m_num] && mask_n[m_num] && en_n)) m_req = 1'b0;
    end else if (m_gap && !(intAck && stack_bits()[m_num] && clr[m_num])) begin
      m_gap = 1'b0;
    end else if (!m_gap && sel >= 0) begin
      m_req = 1'b1;
      m_num = sel[1:0];
    end
    m_pend = pend_n; m_mask = mask_n; m_en = en_n; m_prev = irq;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic write_reg(input logic [7:0] ofs, input logic [7:0] val);
    w_en = 1'b1; address = BASE + ofs; din = val;
    step();
    w_en = 1'b0;
  endtask

  task automatic read_reg(input logic [7:0] ofs, output logic [7:0] val);
    r_en = 1'b1; address = BASE + ofs;
    step();
    r_en = 1'b0;
    val = dout;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset = 1'b0; model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL reset_int got %0h want 0", interrupt); end
    checks++; if (irqNum !== 2'd0) begin errors++; $display("FAIL reset_irqnum got %0h want 0", irqNum); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %0h want 0", dout); end
    @(negedge clk); reset = 1'b1;
    for (int r = 0; r < 4; r++) begin
      read_reg(8'(r), v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_reg%0d got %0h want 0", r, v); end
    end
    read_reg(8'd4, v);
    checks++; if (v[2:0] !== 3'b000) begin errors++; $display("FAIL reset_status got %0h want 0", v[2:0]); end
  endtask

  task automatic test_basic();
    logic [7:0] v;
    write_reg(8'd0, 8'h01);
    write_reg(8'd1, 8'h0F);
    irq = 4'b0100; step(); irq = 4'b0000;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL basic_early got %0h want 0", interrupt); end
    r_en = 1'b1; address = BASE + 8'd2; step(); r_en = 1'b0;
    checks++; if (dout !== 8'h04) begin errors++; $display("FAIL basic_pending got %0h want 04", dout); end
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL basic_int got %0h want 1", interrupt); end
    checks++; if (irqNum !== 2'd2) begin errors++; $display("FAIL basic_num got %0h want 2", irqNum); end
    step(); step();
    intAck = 1'b1; step(); intAck = 1'b0;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL basic_ackdrop got %0h want 0", interrupt); end
    read_reg(8'd3, v);
    checks++; if (v !== 8'h04) begin errors++; $display("FAIL basic_insvc got %0h want 04", v); end
    read_reg(8'd2, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL basic_pendclr got %0h want 0", v); end
  endtask

  task automatic test_nesting();
    logic [7:0] v;
    irq = 4'b1000; step(); irq = 4'b0000; step(); step();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL nest_block3 got %0h want 0", interrupt); end
    irq = 4'b0010; step(); irq = 4'b0000; step();
    checks++; if (interrupt !== 1'b1 || irqNum !== 2'd1) begin errors++; $display("FAIL nest_req1 got %0h/%0h want 1/1", interrupt, irqNum); end
    intAck = 1'b1; step(); intAck = 1'b0;
    read_reg(8'd3, v);
    checks++; if (v !== 8'h06) begin errors++; $display("FAIL nest_insvc2 got %0h want 06", v); end
    intDone = 1'b1; step(); intDone = 1'b0;
    read_reg(8'd3, v);
    checks++; if (v !== 8'h04) begin errors++; $display("FAIL nest_done1 got %0h want 04", v); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL nest_still_block got %0h want 0", interrupt); end
    intDone = 1'b1; step(); intDone = 1'b0;
    step();
    checks++; if (interrupt !== 1'b1 || irqNum !== 2'd3) begin errors++; $display("FAIL nest_req3 got %0h/%0h want 1/3", interrupt, irqNum); end
    intAck = 1'b1; step(); intAck = 1'b0;
    intDone = 1'b1; step(); intDone = 1'b0;
  endtask

  task automatic test_simultaneous();
    irq = 4'b1001; step(); irq = 4'b0000; step();
    checks++; if (interrupt !== 1'b1 || irqNum !== 2'd0) begin errors++; $display("FAIL simul_first got %0h/%0h want 1/0", interrupt, irqNum); end
    intAck = 1'b1; step(); intAck = 1'b0;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL simul_acked got %0h want 0", interrupt); end
    step();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL simul_blocked got %0h want 0", interrupt); end
    intDone = 1'b1; step(); intDone = 1'b0;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL simul_donecycle got %0h want 0", interrupt); end
    step();
    checks++; if (interrupt !== 1'b1 || irqNum !== 2'd3) begin errors++; $display("FAIL simul_second got %0h/%0h want 1/3", interrupt, irqNum); end
    intAck = 1'b1; step(); intAck = 1'b0;
    intDone = 1'b1; step(); intDone = 1'b0;
  endtask

  task automatic test_withdraw();
    logic [7:0] v;
    irq = 4'b0010; step(); irq = 4'b0000; step();
    checks++; if (interrupt !== 1'b1 || irqNum !== 2'd1) begin errors++; $display("FAIL wd_req got %0h/%0h want 1/1", interrupt, irqNum); end
    write_reg(8'd2, 8'h02);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL wd_w1c got %0h want 0", interrupt); end
    read_reg(8'd4, v);
    checks++; if (v[2] !== 1'b0) begin errors++; $display("FAIL wd_status got %0h want 0", v[2]); end
    read_reg(8'd3, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL wd_insvc got %0h want 0", v); end
    irq = 4'b0010; step(); irq = 4'b0000; step();
    checks++; if (interrupt !== 1'b1 || irqNum !== 2'd1) begin errors++; $display("FAIL wd_req2 got %0h/%0h want 1/1", interrupt, irqNum); end
    write_reg(8'd1, 8'h0D);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL wd_mask got %0h want 0", interrupt); end
    read_reg(8'd3, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL wd_insvc2 got %0h want 0", v); end
    write_reg(8'd2, 8'h02);
    write_reg(8'd1, 8'h0F);
  endtask

  task automatic test_level_w1c();
    logic [7:0] v;
    int bad = 0;
    write_reg(8'd1, 8'h00);
    irq = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++; if (interrupt !== 1'b0) begin errors++; bad++; if (bad < 3) $display("FAIL lvl_masked cyc%0d got %0h want 0", c, interrupt); end
    end
    read_reg(8'd2, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL lvl_pending got %0h want 02", v); end
    write_reg(8'd1, 8'h02);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL lvl_unmask1 got %0h want 0", interrupt); end
    step();
    checks++; if (interrupt !== 1'b1 || irqNum !== 2'd1) begin errors++; $display("FAIL lvl_unmask2 got %0h/%0h want 1/1", interrupt, irqNum); end
    intAck = 1'b1; step(); intAck = 1'b0;
    intDone = 1'b1; step(); intDone = 1'b0;
    read_reg(8'd2, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL lvl_noreset got %0h want 0", v); end
    write_reg(8'd1, 8'h00);
    irq = 4'b0000; step();
    irq = 4'b0010; w_en = 1'b1; address = BASE + 8'd2; din = 8'h02; step(); w_en = 1'b0; irq = 4'b0000;
    read_reg(8'd2, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL lvl_setwins got %0h want 02", v); end
    write_reg(8'd2, 8'h02);
    write_reg(8'd1, 8'h0F);
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    irq = 4'b0100; step(); irq = 4'b0000; step();
    checks++; if (interrupt !== 1'b1 || irqNum !== 2'd2) begin errors++; $display("FAIL rst_req got %0h/%0h want 1/2", interrupt, irqNum); end
    #2 reset = 1'b0;
    #1;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rst_async_int got %0h want 0", interrupt); end
    checks++; if (irqNum !== 2'd0) begin errors++; $display("FAIL rst_async_num got %0h want 0", irqNum); end
    @(negedge clk); @(negedge clk);
    reset = 1'b1; model_reset();
    intAck = 1'b1; step(); intAck = 1'b0;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rst_ack_int got %0h want 0", interrupt); end
    for (int r = 0; r < 4; r++) begin
      read_reg(8'(r), v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL rst_reg%0d got %0h want 0", r, v); end
    end
  endtask

  task automatic test_random();
    int bad = 0;
    int k;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1; model_reset(); irq = 4'b0000;
    write_reg(8'd0, 8'h01);
    write_reg(8'd1, 8'h0F);
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) irq[b] = ~irq[b];
      intAck  = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      intDone = ($urandom_range(0, 11) == 0);
      w_en    = ($urandom_range(0, 11) == 0);
      r_en    = ($urandom_range(0, 3) == 0);
      if (w_en) begin
        k = $urandom_range(0, 3);
        din = 8'($urandom);
        if (k == 0) din[0] = ($urandom_range(0, 7) != 0);
        address = BASE + ((k == 3) ? 8'd7 : 8'(k));
      end else if (r_en) begin
        k = $urandom_range(0, 5);
        address = (k < 4) ? BASE + 8'(k) : ((k == 4) ? BASE + 8'd5 : 8'h00);
      end
      step();
      checks++;
      if (interrupt !== m_req || irqNum !== m_num || dout !== m_dout) begin
        errors++; bad++;
        if (bad < 6) $display("FAIL rand cyc%0d got int=%0h num=%0h dout=%0h want int=%0h num=%0h dout=%0h",
                              c, interrupt, irqNum, dout, m_req, m_num, m_dout);
      end
    end
    intAck = 1'b0; intDone = 1'b0; w_en = 1'b0; r_en = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_nesting();
    test_simultaneous();
    test_withdraw();
    test_level_w1c();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_sequencer.md
Name: int_sequencer

Overview:
- Interrupt sequencer between the peripherals' irq lines and the CPU's interrupt interface.
- Detects rising edges on four irq lines and latches them as pending.
- Applies a software mask and global enable, then arbitrates by fixed priority; irq 0 is highest.
- Tracks in-service levels for nesting and runs the interrupt/intAck/intDone handshake with the CPU. Its registers are memory-mapped on the 8-bit I/O bus.

Parameters:
- SEQ_ADDRESS, 8'h00, base I/O address of the register block.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-low reset.
- din  input  8  I/O write data.
- address  input  8  I/O address.
- w_en  input  1  I/O write strobe.
- r_en  input  1  I/O read strobe.
- dout  output  8  I/O read data.
- interrupt  output  1  interrupt request to the CPU.
- irqNum  output  2  index of the interrupt being requested.
- intAck  input  1  CPU accepts the request; one-cycle pulse.
- intDone  input  1  CPU executed return-from-interrupt; one-cycle pulse.
- irq_0 .. irq_3  input  1 each  peripheral requests, synchronous to clk.

Behaviour:
- Reset (reset low, asynchronous):
  - pending, mask, in_service, enable and the irq edge-history registers go to 0.
  - State goes to IDLE; interrupt=0, irqNum=0, dout=0.
- Registers (offset from SEQ_ADDRESS):
  - +0 CTRL (R/W): bit0 global enable; other bits read 0.
  - +1 MASK (R/W): bits[3:0]; 1 = irq enabled.
  - +2 PENDING (R / W1C): bits[3:0].
  - +3 IN_SERVICE (read-only).
  - +4 STATUS (read-only): bits[1:0] irqNum, bit2 interrupt, bits[4:3] state encoding.
- Bus access:
  - Writes take effect at the clk edge where w_en=1.
  - Reads: dout is registered and valid the cycle after r_en=1. dout holds its last value otherwise; unmapped addresses read 0.
- Edge detect:
  - pending[i] sets on the cycle irq_i is 1 and was 0 the previous cycle. Level-held irqs do not re-set pending.
  - Set has priority over a same-cycle W1C clear of the same bit.
- Eligible set: pending & mask, gated by enable. An eligible irq i is serviceable only if i is strictly higher priority (lower index) than the highest-priority bit set in in_service, or in_service is 0.
- FSM:
  - IDLE:
    - If any serviceable irq exists, register irqNum = highest-priority serviceable index, set interrupt=1 and go to ASSERT.
    - interrupt rises on the clk edge after pending is visible. irq edge at cycle n -> pending at n+1 -> interrupt at n+2.
  - ASSERT:
    - irqNum is frozen and interrupt stays 1 until intAck, even if a higher-priority irq becomes pending.
    - Withdraw: if pending[irqNum] is cleared by W1C, or mask[irqNum] or enable drops, return to IDLE with interrupt=0 on the next edge and no in_service change.
    - On intAck: clear pending[irqNum], set in_service[irqNum], set interrupt=0, go to ACKED.
  - ACKED: one cycle with interrupt=0, then IDLE. This guarantees deassertion for at least one cycle between requests.
- intDone:
  - Clears the highest-priority set bit of in_service.
  - Ignored when in_service=0; legal in any state.
  - If intDone and intAck fall in the same cycle, the clear uses the pre-cycle in_service, then the acked bit is set.
- intAck outside ASSERT is ignored.
- Nesting:
  - A lower- or equal-priority pending irq waits until intDone clears the blocking in_service bit.
  - Maximum nesting depth is 4.
- Reset asserted mid-handshake: everything clears immediately. interrupt drops asynchronously and no further intAck is honoured.

Test Plan:
- Reset release; write CTRL=1, MASK=4'hF; pulse irq_2 at cycle 10. Expect PENDING=4'b0100 at 11, interrupt=1/irqNum=2 at 12. intAck at 14 -> interrupt=0 at 15, IN_SERVICE=4'b0100, PENDING=0.
- With irq 2 in service, pulse irq_3 then irq_1. Expect no request for 3, request irqNum=1. Ack it -> IN_SERVICE=4'b0110. intDone -> 4'b0100. intDone -> 0, then irqNum=3 is requested.
- Pulse irq_0 and irq_3 in the same cycle. Expect irqNum=0 first. After ack, ACKED cycle, and intDone, expect irqNum=3.
- In ASSERT with irqNum=1, write PENDING=4'b0010 (W1C). Expect interrupt=0 next edge, FSM IDLE, IN_SERVICE unchanged. Repeat with a MASK bit-1 clear: same result.
- Hold irq_1 high for 20 cycles with MASK=0. Expect one pending set, no interrupt. Write MASK=4'b0010 -> interrupt two edges later. Same-cycle irq edge plus W1C leaves the bit set.
- Assert reset low during ASSERT. Expect interrupt=0 with no clk edge and all registers 0; an intAck after release is ignored.
